// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port data RAM between a core port (0) and a debug/loader port (1)
// Build option: define ARB_FIXED_PRIORITY_EN to make port 0 win every tie (default is round-robin).
// Ports:
//   clk_i, reset_i                              clock (rising edge), asynchronous active-high reset
//   mN_req_i, mN_we_i, mN_addr_i, mN_wdata_i    port N command, held stable until mN_gnt_o
//   mN_gnt_o                                    port N command accepted (1-cycle pulse)
//   mN_rvalid_o, mN_rdata_o                     port N read-valid pulse, read data held until next port N read
//   ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o RAM command bus (addr/wdata hold their last driven value)
//   ram_rdata_i                                 RAM read data, valid RAM_LATENCY cycles after a read strobe
//   busy_o                                      an access is being sequenced
module ram_access_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  busy_o
);
    if (RAM_LATENCY < 1 || RAM_LATENCY > 15) begin : g_bad_latency
        $error("ram_access_arbiter: RAM_LATENCY must be within 1..15");
    end
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                  pick;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
`ifdef ARB_FIXED_PRIORITY_EN
    assign pick = ~m0_req_i;
`else
    // On a tie the port that did not win the previous access goes next.
    assign pick = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
`endif
    // The owner's command is taken live in ISSUE; requesters hold it through gnt.
    assign sel_we    = owner_q ? m1_we_i    : m0_we_i;
    assign sel_addr  = owner_q ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = owner_q ? m1_wdata_i : m0_wdata_i;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        ram_en_o  = 1'b0;
        ram_we_o  = 1'b0;
        m0_gnt_o  = 1'b0;
        m1_gnt_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    owner_d = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ram_en_o = 1'b1;
                ram_we_o = sel_we;
                addr_d   = sel_addr;
                wdata_d  = sel_wdata;
                m0_gnt_o = ~owner_q;
                m1_gnt_o = owner_q;
                last_d   = owner_q;
                state_d  = sel_we ? IDLE : WAIT;
                cnt_d    = sel_we ? cnt_q : 4'(RAM_LATENCY);
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Last wait cycle: RAM data is valid now, present it next cycle.
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rdata1_d  = ram_rdata_i;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = ram_rdata_i;
                        rvalid0_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Address/data follow the owner in ISSUE and otherwise hold the last driven value.
    assign ram_addr_o  = addr_d;
    assign ram_wdata_o = wdata_d;
    assign m0_rvalid_o = rvalid0_q;
    assign m1_rvalid_o = rvalid1_q;
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
    assign busy_o      = state_q != IDLE;
endmodule
